// File: rtl/traffic_pkg.sv
// Shared state codes, lamp encodings and default phase durations for the
// intersection controller. NIGHT_FLASH_EN adds the night flashing state code.
package traffic_pkg;

    // Phase state codes
    localparam logic [2:0] ST_MAIN_GREEN  = 3'd0;
    localparam logic [2:0] ST_MAIN_YELLOW = 3'd1;
    localparam logic [2:0] ST_ALL_RED_A   = 3'd2;
    localparam logic [2:0] ST_WALK        = 3'd3;
    localparam logic [2:0] ST_SIDE_GREEN  = 3'd4;
    localparam logic [2:0] ST_SIDE_YELLOW = 3'd5;
    localparam logic [2:0] ST_ALL_RED_B   = 3'd6;
`ifdef NIGHT_FLASH_EN
    localparam logic [2:0] ST_NIGHT_FLASH = 3'd7;
`endif

    // Lamp encodings {red,yellow,green}
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    // Default durations in 1 Hz ticks
    localparam int unsigned DEF_CNT_W        = 4;
    localparam int unsigned DEF_T_MAIN_GREEN = 8;
    localparam int unsigned DEF_T_YELLOW     = 3;
    localparam int unsigned DEF_T_ALL_RED    = 1;
    localparam int unsigned DEF_T_SIDE_GREEN = 6;
    localparam int unsigned DEF_T_WALK       = 5;

    // Countdown load value for a duration; a zero duration behaves as one tick
    function automatic int unsigned dur_to_load(input int unsigned t);
        return (t == 0) ? 0 : t - 1;
    endfunction

endpackage

// File: rtl/phase_countdown.sv
// Loadable down-counter that times each phase. Load wins over tick; the
// count saturates at zero so a holding phase stays expired.
module phase_countdown #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             zero_c
);

    assign zero_c = (count == '0);

    // Load on phase entry, otherwise count ticks down to zero
    always_ff @(posedge clk) begin
        if (load) begin
            count <= load_value;
        end else if (tick && !zero_c) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/traffic_phase_controller.sv
// Two-road intersection phase sequencer with pedestrian walk phase.
// Define NIGHT_FLASH_EN to enable the night flashing mode driven by night_mode.
module traffic_phase_controller
    import traffic_pkg::*;
#(
    parameter int unsigned CNT_W        = DEF_CNT_W,
    parameter int unsigned T_MAIN_GREEN = DEF_T_MAIN_GREEN,
    parameter int unsigned T_YELLOW     = DEF_T_YELLOW,
    parameter int unsigned T_ALL_RED    = DEF_T_ALL_RED,
    parameter int unsigned T_SIDE_GREEN = DEF_T_SIDE_GREEN,
    parameter int unsigned T_WALK       = DEF_T_WALK
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       oneHz_enable,
    input  logic       sensor,
    input  logic       walk_req,
    input  logic       night_mode,
    output logic [2:0] main_lights,
    output logic [2:0] side_lights,
    output logic       walk_lamp,
    output logic [2:0] phase
);

    localparam logic [CNT_W-1:0] LD_MAIN_GREEN = CNT_W'(dur_to_load(T_MAIN_GREEN));
    localparam logic [CNT_W-1:0] LD_YELLOW     = CNT_W'(dur_to_load(T_YELLOW));
    localparam logic [CNT_W-1:0] LD_ALL_RED    = CNT_W'(dur_to_load(T_ALL_RED));
    localparam logic [CNT_W-1:0] LD_SIDE_GREEN = CNT_W'(dur_to_load(T_SIDE_GREEN));
    localparam logic [CNT_W-1:0] LD_WALK       = CNT_W'(dur_to_load(T_WALK));

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic             walk_pending;
    logic             pending_nxt;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_value;
    logic [CNT_W-1:0] cnt_count;
    logic             cnt_zero;
    logic             expire;
    logic [2:0]       main_nxt;
    logic [2:0]       side_nxt;
    logic             walk_nxt;

`ifdef NIGHT_FLASH_EN
    logic flash;
    logic flash_nxt;
`else
    logic unused_night;
    assign unused_night = night_mode;
`endif

    // Phase timer; reset forces the all-red clearance duration
    phase_countdown #(
        .CNT_W (CNT_W)
    ) u_countdown (
        .clk        (clk),
        .load       (reset | cnt_load),
        .load_value (reset ? LD_ALL_RED : cnt_value),
        .tick       (oneHz_enable),
        .count      (cnt_count),
        .zero_c     (cnt_zero)
    );

    assign expire = oneHz_enable && cnt_zero;
    assign phase  = state;

    // Next state, countdown reload, walk request tracking and lamp decode
    always_comb begin
        state_nxt   = state;
        pending_nxt = walk_pending;
        cnt_load    = 1'b0;
        cnt_value   = '0;
        main_nxt    = LAMP_RED;
        side_nxt    = LAMP_RED;
        walk_nxt    = 1'b0;
`ifdef NIGHT_FLASH_EN
        flash_nxt   = flash;
`endif

        if (expire) begin
            case (state)
                ST_MAIN_GREEN:  if (sensor || walk_pending) state_nxt = ST_MAIN_YELLOW;
                ST_MAIN_YELLOW: state_nxt = ST_ALL_RED_A;
                ST_ALL_RED_A:   state_nxt = walk_pending ? ST_WALK : ST_SIDE_GREEN;
                ST_WALK:        state_nxt = ST_SIDE_GREEN;
                ST_SIDE_GREEN:  state_nxt = ST_SIDE_YELLOW;
                ST_SIDE_YELLOW: state_nxt = ST_ALL_RED_B;
                ST_ALL_RED_B:   state_nxt = ST_MAIN_GREEN;
                default:        state_nxt = ST_ALL_RED_B;
            endcase
        end

`ifdef NIGHT_FLASH_EN
        // Night flashing overrides normal sequencing; lamps start lit on entry
        if (state == ST_NIGHT_FLASH) begin
            state_nxt = ST_NIGHT_FLASH;
            if (oneHz_enable) begin
                if (night_mode) begin
                    flash_nxt = ~flash;
                end else begin
                    state_nxt = ST_ALL_RED_B;
                end
            end
        end else if (expire && night_mode) begin
            state_nxt = ST_NIGHT_FLASH;
            flash_nxt = 1'b1;
        end
`endif

        if (state_nxt != state) begin
            cnt_load = 1'b1;
            case (state_nxt)
                ST_MAIN_GREEN:  cnt_value = LD_MAIN_GREEN;
                ST_MAIN_YELLOW: cnt_value = LD_YELLOW;
                ST_SIDE_YELLOW: cnt_value = LD_YELLOW;
                ST_ALL_RED_A:   cnt_value = LD_ALL_RED;
                ST_ALL_RED_B:   cnt_value = LD_ALL_RED;
                ST_WALK:        cnt_value = LD_WALK;
                ST_SIDE_GREEN:  cnt_value = LD_SIDE_GREEN;
                default:        cnt_value = '0;
            endcase
        end

        // A request is consumed by entering WALK and ignored while in WALK
        if ((state_nxt == ST_WALK) || (state == ST_WALK)) begin
            pending_nxt = 1'b0;
        end else if (walk_req) begin
            pending_nxt = 1'b1;
        end

        case (state_nxt)
            ST_MAIN_GREEN:  main_nxt = LAMP_GRN;
            ST_MAIN_YELLOW: main_nxt = LAMP_YEL;
            ST_SIDE_GREEN:  side_nxt = LAMP_GRN;
            ST_SIDE_YELLOW: side_nxt = LAMP_YEL;
            ST_WALK:        walk_nxt = 1'b1;
`ifdef NIGHT_FLASH_EN
            ST_NIGHT_FLASH: begin
                main_nxt = flash_nxt ? LAMP_YEL : 3'b000;
                side_nxt = flash_nxt ? LAMP_RED : 3'b000;
            end
`endif
            default: ;
        endcase
    end

    // State, request and lamp registers; lamps move on the same edge as the state
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_ALL_RED_B;
            walk_pending <= 1'b0;
            main_lights  <= LAMP_RED;
            side_lights  <= LAMP_RED;
            walk_lamp    <= 1'b0;
`ifdef NIGHT_FLASH_EN
            flash        <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            walk_pending <= pending_nxt;
            main_lights  <= main_nxt;
            side_lights  <= side_nxt;
            walk_lamp    <= walk_nxt;
`ifdef NIGHT_FLASH_EN
            flash        <= flash_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed bench for traffic_phase_controller with hand-derived phase sequences.
// Night flashing checks are compiled in when NIGHT_FLASH_EN is defined.
module tb_traffic_phase_controller;

    localparam logic [2:0] P_MG  = 3'd0;
    localparam logic [2:0] P_MY  = 3'd1;
    localparam logic [2:0] P_ARA = 3'd2;
    localparam logic [2:0] P_WK  = 3'd3;
    localparam logic [2:0] P_SG  = 3'd4;
    localparam logic [2:0] P_SY  = 3'd5;
    localparam logic [2:0] P_ARB = 3'd6;

    logic       clk = 1'b0;
    logic       reset;
    logic       oneHz_enable;
    logic       sensor;
    logic       walk_req;
    logic       night_mode;
    logic [2:0] main_lights;
    logic [2:0] side_lights;
    logic       walk_lamp;
    logic [2:0] phase;

    int checks   = 0;
    int failures = 0;

    traffic_phase_controller dut (
        .clk          (clk),
        .reset        (reset),
        .oneHz_enable (oneHz_enable),
        .sensor       (sensor),
        .walk_req     (walk_req),
        .night_mode   (night_mode),
        .main_lights  (main_lights),
        .side_lights  (side_lights),
        .walk_lamp    (walk_lamp),
        .phase        (phase)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_lamps(input string tag, input logic [2:0] ph, input logic [2:0] m,
                               input logic [2:0] s, input logic w);
        check_eq({tag, ".phase"}, 8'(phase), 8'(ph));
        check_eq({tag, ".main"},  8'(main_lights), 8'(m));
        check_eq({tag, ".side"},  8'(side_lights), 8'(s));
        check_eq({tag, ".walk"},  8'(walk_lamp), 8'(w));
    endtask

    task automatic check_state(input string tag, input logic [2:0] ph);
        logic [2:0] m;
        logic [2:0] s;
        m = (ph == P_MG) ? 3'b001 : (ph == P_MY) ? 3'b010 : 3'b100;
        s = (ph == P_SG) ? 3'b001 : (ph == P_SY) ? 3'b010 : 3'b100;
        check_lamps(tag, ph, m, s, ph == P_WK);
    endtask

    // One-clk tick followed by idle clocks so frozen cycles are exercised
    task automatic tick();
        @(negedge clk) oneHz_enable = 1'b1;
        @(negedge clk) oneHz_enable = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_seg(input string tag, input logic [2:0] ph, input int n);
        for (int i = 0; i < n; i++) begin
            check_state(tag, ph);
            tick();
        end
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        oneHz_enable = 1'b0;
        sensor       = 1'b0;
        walk_req     = 1'b0;
        night_mode   = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state, freeze without ticks, then main green holds
        check_state("rst", P_ARB);
        repeat (4) @(negedge clk);
        check_state("freeze", P_ARB);
        tick();
        run_seg("hold", P_MG, 20);
        check_state("hold_end", P_MG);

        // Night mode is ignored unless the feature is built in
`ifndef NIGHT_FLASH_EN
        night_mode = 1'b1;
        tick();
        check_state("night_ignored", P_MG);
        night_mode = 1'b0;
`endif

        // Sensor-driven full cycle
        do_reset();
        sensor = 1'b1;
        run_seg("cyc.arb", P_ARB, 1);
        run_seg("cyc.mg",  P_MG,  8);
        run_seg("cyc.my",  P_MY,  3);
        run_seg("cyc.ara", P_ARA, 1);
        run_seg("cyc.sg",  P_SG,  6);
        run_seg("cyc.sy",  P_SY,  3);
        run_seg("cyc.arb2", P_ARB, 1);
        run_seg("cyc.mg2", P_MG,  8);
        check_state("cyc.my2", P_MY);

        // Pulsed walk request during main green
        do_reset();
        sensor = 1'b0;
        run_seg("wp.arb", P_ARB, 1);
        run_seg("wp.mg",  P_MG,  1);
        @(negedge clk) walk_req = 1'b1;
        @(negedge clk) walk_req = 1'b0;
        run_seg("wp.mg",  P_MG,  7);
        run_seg("wp.my",  P_MY,  3);
        run_seg("wp.ara", P_ARA, 1);
        run_seg("wp.walk", P_WK, 5);
        run_seg("wp.sg",  P_SG,  6);
        run_seg("wp.sy",  P_SY,  3);
        run_seg("wp.arb2", P_ARB, 1);
        run_seg("wp.mg2", P_MG,  9);
        check_state("wp.cleared", P_MG);

        // Held walk request is served once
        do_reset();
        walk_req = 1'b1;
        run_seg("wh.arb", P_ARB, 1);
        run_seg("wh.mg",  P_MG,  8);
        run_seg("wh.my",  P_MY,  3);
        run_seg("wh.ara", P_ARA, 1);
        run_seg("wh.walk", P_WK, 2);
        walk_req = 1'b0;
        run_seg("wh.walk", P_WK, 3);
        run_seg("wh.sg",  P_SG,  6);
        run_seg("wh.sy",  P_SY,  3);
        run_seg("wh.arb2", P_ARB, 1);
        run_seg("wh.mg2", P_MG,  9);
        check_state("wh.once", P_MG);

        // Reset in the middle of side green
        do_reset();
        sensor = 1'b1;
        run_seg("mr.arb", P_ARB, 1);
        run_seg("mr.mg",  P_MG,  8);
        run_seg("mr.my",  P_MY,  3);
        run_seg("mr.ara", P_ARA, 1);
        run_seg("mr.sg",  P_SG,  2);
        check_state("mr.sg_mid", P_SG);
        do_reset();
        sensor = 1'b0;
        check_state("mr.rst", P_ARB);
        tick();
        check_state("mr.mg", P_MG);

`ifdef NIGHT_FLASH_EN
        // Night flashing from the main green hold
        do_reset();
        run_seg("nf.arb", P_ARB, 1);
        run_seg("nf.mg",  P_MG,  8);
        night_mode = 1'b1;
        tick();
        check_lamps("nf.on1",  3'd7, 3'b010, 3'b100, 1'b0);
        tick();
        check_lamps("nf.off1", 3'd7, 3'b000, 3'b000, 1'b0);
        tick();
        check_lamps("nf.on2",  3'd7, 3'b010, 3'b100, 1'b0);
        night_mode = 1'b0;
        tick();
        check_state("nf.exit", P_ARB);
        tick();
        check_state("nf.mg", P_MG);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
